// File: rtl/interrupt_arbiter_pkg.sv
// ============================================================================
// Module  : interrupt_arbiter_pkg
// Brief   : Shared FSM encodings and widths for the interrupt arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package interrupt_arbiter_pkg;

    localparam int INT_SRC_W = 64;
    localparam int IDX_W     = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'b001;
    localparam state_t ST_ISSUE   = 3'b010;
    localparam state_t ST_RELEASE = 3'b100;

endpackage

`default_nettype wire

// File: rtl/interrupt_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin search from an internal pointer, advanced on accept.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   w_dist;
    logic [IDX_W:0]   w_best;

    // Winner is the requester with the smallest wrapped distance above ptr_q.
    always_comb begin
        w_best = '1;
        w_dist = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((IDX_W+1)'(i) >= {1'b0, ptr_q}) begin
                w_dist = (IDX_W+1)'(i) - {1'b0, ptr_q};
            end else begin
                w_dist = (IDX_W+1)'(i + N) - {1'b0, ptr_q};
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_grant
        assign grant[g] = any && (idx == IDX_W'(g));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && any) begin
            ptr_d = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_arbiter.sv
// ============================================================================
// Module  : interrupt_arbiter
// Brief   : Shares one interrupt engine among NREQ sources, round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CTXW = 9
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*INT_SRC_W-1:0] req_src,
    input  logic [NREQ*CTXW-1:0]      req_ctx,
    output logic [NREQ-1:0]           req_ack,
    output logic                      int_req,
    output logic [INT_SRC_W-1:0]      int_src,
    output logic [CTXW-1:0]           int_ctx,
    input  logic                      int_ack,
    output logic                      arb_busy,
    output logic [IDX_W-1:0]          grant_idx
);

    state_t                 state_q, state_d;
    logic                   int_req_q, int_req_d;
    logic [INT_SRC_W-1:0]   int_src_q, int_src_d;
    logic [CTXW-1:0]        int_ctx_q, int_ctx_d;
    logic [NREQ-1:0]        req_ack_q, req_ack_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;

    logic [NREQ-1:0]        w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_accept;
    logic [INT_SRC_W-1:0]   w_src;
    logic [CTXW-1:0]        w_ctx;
    logic [NREQ-1:0]        w_ack_dec;

    // A spurious ack still high from the engine blocks any new grant.
    assign w_accept = (state_q == ST_IDLE) && !int_ack && w_any;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk    (clk),
        .resetn (resetn),
        .req    (req_valid),
        .accept (w_accept),
        .grant  (w_grant),
        .idx    (w_idx),
        .any    (w_any)
    );

    always_comb begin
        w_src = '0;
        w_ctx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_src = w_src | req_src[INT_SRC_W*i +: INT_SRC_W];
                w_ctx = w_ctx | req_ctx[CTXW*i +: CTXW];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_ack_dec
        assign w_ack_dec[g] = (grant_idx_q == IDX_W'(g));
    end

    always_comb begin
        state_d     = state_q;
        int_req_d   = int_req_q;
        int_src_d   = int_src_q;
        int_ctx_d   = int_ctx_q;
        grant_idx_d = grant_idx_q;
        req_ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                int_req_d = 1'b0;
                if (w_accept) begin
                    int_src_d   = w_src;
                    int_ctx_d   = w_ctx;
                    grant_idx_d = w_idx;
                    int_req_d   = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                int_req_d = 1'b1;
                if (int_ack) begin
                    int_req_d = 1'b0;
                    req_ack_d = w_ack_dec;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                int_req_d = 1'b0;
                if (!int_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                int_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            int_req_q   <= 1'b0;
            int_src_q   <= '0;
            int_ctx_q   <= '0;
            req_ack_q   <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            int_req_q   <= int_req_d;
            int_src_q   <= int_src_d;
            int_ctx_q   <= int_ctx_d;
            req_ack_q   <= req_ack_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign int_req   = int_req_q;
    assign int_src   = int_src_q;
    assign int_ctx   = int_ctx_q;
    assign req_ack   = req_ack_q;
    assign grant_idx = grant_idx_q;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
// ============================================================================
// Module  : tb_interrupt_arbiter
// Brief   : Directed bench with a behavioural arbiter model and engine stub.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_arbiter;

    localparam int NREQ = 4;
    localparam int CTXW = 9;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*64-1:0]   req_src = '0;
    logic [NREQ*CTXW-1:0] req_ctx = '0;
    logic [NREQ-1:0]      req_ack;
    logic                 int_req;
    logic [63:0]          int_src;
    logic [CTXW-1:0]      int_ctx;
    logic                 int_ack = 1'b0;
    logic                 arb_busy;
    logic [3:0]           grant_idx;

    interrupt_arbiter #(
        .NREQ (NREQ),
        .CTXW (CTXW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_ctx   (req_ctx),
        .req_ack   (req_ack),
        .int_req   (int_req),
        .int_src   (int_src),
        .int_ctx   (int_ctx),
        .int_ack   (int_ack),
        .arb_busy  (arb_busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model: phase 0 = waiting, 1 = engine owns request, 2 = draining ack.
    int              m_phase = 0;
    int              m_ptr = 0;
    int              m_idx = 0;
    logic [63:0]     m_src = '0;
    logic [CTXW-1:0] m_ctx = '0;
    logic            m_req = 1'b0;
    logic [NREQ-1:0] m_ack = '0;

    // Engine stub and requester behaviour.
    bit eng_en = 1'b1;
    bit auto_drop = 1'b1;
    int eng_delay = 10;
    int eng_hold = 0;
    int eng_cnt = 0;
    int hold_cnt = 0;

    int   cyc = 0;
    int   t_fall = 0;
    int   t_rise = 0;
    int   viol = 0;
    int   ack_cnt = 0;
    logic [NREQ-1:0] last_ack = '0;
    logic prev_req = 1'b0;
    int   g_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int w;
        int c;
        if (!resetn) begin
            m_phase = 0; m_ptr = 0; m_idx = 0;
            m_src = '0; m_ctx = '0; m_req = 1'b0; m_ack = '0;
        end else begin
            m_ack = '0;
            case (m_phase)
                0: if (req_valid != 0 && !int_ack) begin
                    w = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (w < 0 && req_valid[c]) w = c;
                    end
                    m_idx   = w;
                    m_src   = req_src[64*w +: 64];
                    m_ctx   = req_ctx[CTXW*w +: CTXW];
                    m_req   = 1'b1;
                    m_ptr   = (w + 1) % NREQ;
                    m_phase = 1;
                end
                1: if (int_ack) begin
                    m_req   = 1'b0;
                    m_ack   = NREQ'(1 << m_idx);
                    m_phase = 2;
                end
                default: if (!int_ack) m_phase = 0;
            endcase
        end
    endtask

    // One clock: model update at the edge, stub reactions just after, compare at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        cyc++;
        if (int_req && !prev_req) begin
            g_log.push_back(int'(grant_idx));
            t_rise = cyc;
            if (int_ack) viol++;
        end
        prev_req = int_req;
        if (req_ack != 0) begin
            ack_cnt++;
            last_ack = req_ack;
        end
        if (auto_drop) req_valid = req_valid & ~req_ack;
        if (!resetn) begin
            int_ack = 1'b0; eng_cnt = 0; hold_cnt = 0;
        end else if (eng_en) begin
            if (int_req && !int_ack) begin
                eng_cnt++;
                if (eng_cnt >= eng_delay) begin
                    int_ack = 1'b1;
                    eng_cnt = 0;
                end
            end else if (int_ack && !int_req) begin
                if (hold_cnt >= eng_hold) begin
                    int_ack  = 1'b0;
                    hold_cnt = 0;
                    t_fall   = cyc;
                end else begin
                    hold_cnt++;
                end
            end
        end
        @(negedge clk);
        chk("int_req",   64'(int_req),   64'(m_req));
        chk("int_src",   int_src,        m_src);
        chk("int_ctx",   64'(int_ctx),   64'(m_ctx));
        chk("req_ack",   64'(req_ack),   64'(m_ack));
        chk("arb_busy",  64'(arb_busy),  64'(m_phase != 0));
        chk("grant_idx", 64'(grant_idx), 64'(m_idx));
    endtask

    task automatic run_until_grants(input int n, input int budget, input string name);
        for (int i = 0; i < budget && g_log.size() < n; i++) step();
        chk(name, 64'(g_log.size()), 64'(n));
    endtask

    task automatic run_until_ack(input int budget, input string name);
        ack_cnt = 0;
        for (int i = 0; i < budget && ack_cnt == 0; i++) step();
        chk(name, 64'(ack_cnt), 64'd1);
    endtask

    initial begin
        step();
        step();
        chk("reset_int_req",   64'(int_req),   64'd0);
        chk("reset_busy",      64'(arb_busy),  64'd0);
        chk("reset_grant_idx", 64'(grant_idx), 64'd0);
        chk("reset_int_src",   int_src,        64'd0);
        resetn = 1'b1;
        step();

        // Single request from requester 2, engine acks after 10 clocks.
        req_src[2*64 +: 64]     = 64'hDEAD_BEEF;
        req_ctx[2*CTXW +: CTXW] = 9'h05;
        req_valid = 4'b0100;
        g_log.delete();
        step();
        chk("t1_latency_int_req", 64'(int_req),   64'd1);
        chk("t1_int_src",         int_src,        64'hDEAD_BEEF);
        chk("t1_int_ctx",         64'(int_ctx),   64'h5);
        chk("t1_grant_idx",       64'(grant_idx), 64'd2);
        run_until_ack(40, "t1_ack_seen");
        for (int i = 0; i < 4; i++) step();
        chk("t1_ack_pulses", 64'(ack_cnt),  64'd1);
        chk("t1_ack_vector", 64'(last_ack), 64'b0100);

        // Wrap: pointer sits at 3, requesters 3 and 0 pending.
        eng_delay = 3;
        req_src[3*64 +: 64] = 64'h3333_0003;
        req_src[0*64 +: 64] = 64'h0000_0A00;
        req_valid = 4'b1001;
        g_log.delete();
        run_until_grants(2, 60, "t3_two_grants");
        run_until_ack(40, "t3_second_ack");
        req_valid = 4'b0000;
        step();
        req_valid = 4'b1111;
        run_until_grants(3, 60, "t3_third_grant");
        run_until_ack(40, "t3_third_ack");
        req_valid = 4'b0000;
        chk("t3_first",  64'(g_log[0]), 64'd3);
        chk("t3_second", 64'(g_log[1]), 64'd0);
        chk("t3_ptr_back_to_1", 64'(g_log[2]), 64'd1);
        for (int i = 0; i < 3; i++) step();

        // Source changes while the interrupt is in flight must not leak through.
        req_src[1*64 +: 64] = 64'hAAAA_1111;
        req_valid = 4'b0010;
        g_log.delete();
        run_until_grants(1, 20, "t6_grant");
        req_src[1*64 +: 64] = 64'hBBBB_2222;
        step();
        chk("t6_src_held", int_src, 64'hAAAA_1111);
        run_until_ack(40, "t6_ack");
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // Engine keeps int_ack high for 5 clocks after int_req drops.
        eng_hold = 5;
        ack_cnt = 0;
        viol = 0;
        req_valid = 4'b0011;
        g_log.delete();
        run_until_grants(2, 80, "t4_two_grants");
        chk("t4_order0",       64'(g_log[0]), 64'd0);
        chk("t4_order1",       64'(g_log[1]), 64'd1);
        chk("t4_single_ack",   64'(ack_cnt),  64'd1);
        chk("t4_regrant_gap",  64'(t_rise - t_fall), 64'd2);
        chk("t4_no_req_in_ack", 64'(viol),    64'd0);
        run_until_ack(60, "t4_final_ack");
        req_valid = 4'b0000;
        eng_hold = 0;
        for (int i = 0; i < 8; i++) step();

        // Spurious ack while idle blocks grants until it falls.
        eng_en = 1'b0;
        int_ack = 1'b1;
        req_valid = 4'b0001;
        g_log.delete();
        for (int i = 0; i < 3; i++) step();
        chk("t7_no_grant",   64'(int_req),  64'd0);
        chk("t7_idle",       64'(arb_busy), 64'd0);
        int_ack = 1'b0;
        eng_en = 1'b1;
        run_until_grants(1, 5, "t7_grant_after_fall");
        chk("t7_grant_idx", 64'(g_log[0]), 64'd0);
        run_until_ack(40, "t7_ack");
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // Reset while in ISSUE, then fairness with all four held continuously.
        req_valid = 4'b0100;
        g_log.delete();
        run_until_grants(1, 20, "t5_grant");
        step();
        resetn = 1'b0;
        step();
        chk("t5_rst_int_req", 64'(int_req),  64'd0);
        chk("t5_rst_req_ack", 64'(req_ack),  64'd0);
        chk("t5_rst_busy",    64'(arb_busy), 64'd0);
        resetn = 1'b1;
        auto_drop = 1'b0;
        req_valid = 4'b1111;
        g_log.delete();
        prev_req = 1'b0;
        run_until_grants(6, 200, "t2_six_grants");
        chk("t2_g0", 64'(g_log[0]), 64'd0);
        chk("t2_g1", 64'(g_log[1]), 64'd1);
        chk("t2_g2", 64'(g_log[2]), 64'd2);
        chk("t2_g3", 64'(g_log[3]), 64'd3);
        chk("t2_g4", 64'(g_log[4]), 64'd0);
        chk("t2_g5", 64'(g_log[5]), 64'd1);
        run_until_ack(40, "t2_last_ack");
        req_valid = 4'b0000;
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
